// File: rtl/cpu_mem_responder.sv
// Bus target for the cpu memory port: word RAM plus an IO page holding
// a console TX FIFO, a free-running cycle counter and a scratch register.
//
// Ports: clk, rst (sync, active-high); mem_re/mem_we/memaddr/wmemdata in,
//   rmemdata out (1-cycle registered read); tx_data/tx_valid/tx_ready
//   console drain; scratch out.
// Option: MEMRSP_FAULT_EN adds fault/fault_addr and traps alias/unmapped
//   accesses (read returns 32'hDEADBEEF, write suppressed).
module cpu_mem_responder #(
  parameter int RAM_AW  = 12,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [29:0] memaddr,
  input  logic [31:0] wmemdata,
  output logic [31:0] rmemdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] scratch
`ifdef MEMRSP_FAULT_EN
  ,
  output logic        fault,
  output logic [29:0] fault_addr
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [31:0]        r_ram [2**RAM_AW];
  logic [7:0]         r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;
  logic [31:0]        r_cycles;
  logic [31:0]        r_scratch;
  logic [31:0]        r_rdata;

  logic               w_rd;
  logic               w_wr;
  logic               w_io;
  logic [3:0]         w_off;
  logic               w_bad;
  logic               w_ram_we;
  logic               w_io_we;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_req;
  logic               w_push_ok;
  logic [31:0]        w_status;
  logic [31:0]        w_io_rdata;
  logic               w_unused;

  // Read wins over write when both strobes are high.
  assign w_rd      = mem_re;
  assign w_wr      = mem_we & ~mem_re;
  assign w_io      = memaddr[29];
  assign w_off     = memaddr[3:0];
  assign w_ram_idx = memaddr[RAM_AW-1:0];
  assign w_unused  = &{1'b0, memaddr[28:RAM_AW]};

`ifdef MEMRSP_FAULT_EN
  logic        r_fault;
  logic [29:0] r_fault_addr;

  assign w_bad = w_io ? (|w_off[3:2])
                      : (|memaddr[28:RAM_AW]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if ((mem_re | mem_we) & w_bad & ~r_fault) begin
      r_fault      <= 1'b1;
      r_fault_addr <= memaddr;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`else
  assign w_bad = 1'b0;
`endif

  assign w_ram_we = w_wr & ~w_bad & ~w_io;
  assign w_io_we  = w_wr & ~w_bad & w_io;

  assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & tx_ready;
  assign w_push_req = w_io_we & (w_off == 4'd0);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);

  assign w_status = {24'b0, 4'(r_count), 1'b0, r_ovf, w_empty, w_full};

  always_comb begin
    w_io_rdata = '0;
    case (w_off)
      4'd0:    w_io_rdata = {24'b0, tx_data};
      4'd1:    w_io_rdata = w_status;
      4'd2:    w_io_rdata = r_cycles;
      4'd3:    w_io_rdata = r_scratch;
      default: w_io_rdata = '0;
    endcase
  end

  // RAM and FIFO storage carry no reset; validity lives in r_count.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= wmemdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_fifo[r_wp] <= wmemdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata   <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_cycles  <= '0;
      r_scratch <= '0;
    end else begin
      if (w_rd) begin
        if (w_bad)     r_rdata <= 32'hDEADBEEF;
        else if (w_io) r_rdata <= w_io_rdata;
        else           r_rdata <= r_ram[w_ram_idx];
      end

      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_push_req & ~w_push_ok)
        r_ovf <= 1'b1;
      else if (w_io_we & (w_off == 4'd1))
        r_ovf <= 1'b0;

      if (w_io_we & (w_off == 4'd2)) r_cycles <= wmemdata;
      else                           r_cycles <= r_cycles + 1'b1;

      if (w_io_we & (w_off == 4'd3)) r_scratch <= wmemdata;
    end
  end

  assign rmemdata = r_rdata;
  assign tx_valid = ~w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rp];
  assign scratch  = r_scratch;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: RAM, IO page, console FIFO,
// cycle counter wrap and read/write collision.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re;
  logic        mem_we;
  logic [29:0] memaddr;
  logic [31:0] wmemdata;
  logic [31:0] rmemdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] scratch;
`ifdef MEMRSP_FAULT_EN
  logic        fault;
  logic [29:0] fault_addr;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [29:0] IO_CON = 30'h20000000;
  localparam logic [29:0] IO_STA = 30'h20000001;
  localparam logic [29:0] IO_CYC = 30'h20000002;
  localparam logic [29:0] IO_SCR = 30'h20000003;

  cpu_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .memaddr   (memaddr),
    .wmemdata  (wmemdata),
    .rmemdata  (rmemdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .scratch   (scratch)
`ifdef MEMRSP_FAULT_EN
    ,
    .fault     (fault),
    .fault_addr(fault_addr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic re, input logic we,
                     input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_re   = re;
    mem_we   = we;
    memaddr  = a;
    wmemdata = d;
    @(posedge clk);
    #1;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    memaddr  = 'x;
    wmemdata = 'x;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    bus(1'b1, 1'b0, a, '0);
    d = rmemdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input logic [7:0] first);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      check(tag, {24'b0, tx_data}, {24'b0, first + 8'(i)});
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check({tag, "_empty"}, {31'b0, tx_valid}, 32'd0);
  endtask

  logic [31:0] v;

  initial begin
    rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0;
    memaddr = 'x; wmemdata = 'x; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rmemdata, 32'd0);
    check("rst_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_txdata", {24'b0, tx_data}, 32'd0);
    check("rst_scratch", scratch, 32'd0);
`ifdef MEMRSP_FAULT_EN
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_faddr", {2'b0, fault_addr}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    rd(IO_STA, v);
    check("rst_status", v, 32'h00000002);

    // RAM write then read, data held while idle
    wr(30'd5, 32'h12345678);
    rd(30'd5, v);
    check("ram_rd5", v, 32'h12345678);
    idle(3);
    check("ram_hold", rmemdata, 32'h12345678);

    // Scratch
    wr(IO_SCR, 32'hA5A5A5A5);
    check("scratch_out", scratch, 32'hA5A5A5A5);
    rd(IO_SCR, v);
    check("scratch_rd", v, 32'hA5A5A5A5);

    // FIFO overflow then drain
    for (int i = 0; i < 5; i++) wr(IO_CON, 32'h41 + i);
    rd(IO_STA, v);
    check("fifo_status_full", v, 32'h00000045);
    rd(IO_CON, v);
    check("console_rd", v, 32'h00000041);
    check("fifo_valid", {31'b0, tx_valid}, 32'd1);
    drain("drain1", 8'h41);
    rd(IO_STA, v);
    check("status_ovf_kept", v, 32'h00000006);
    wr(IO_STA, 32'hFFFFFFFF);
    rd(IO_STA, v);
    check("status_ovf_clr", v, 32'h00000002);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(IO_CON, 32'h51 + i);
    @(negedge clk);
    tx_ready = 1'b1;
    mem_we   = 1'b1;
    memaddr  = IO_CON;
    wmemdata = 32'h00000055;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    mem_we   = 1'b0;
    memaddr  = 'x;
    rd(IO_STA, v);
    check("pushpop_status", v, 32'h00000041);
    drain("drain2", 8'h52);

    // Cycle counter wrap
    wr(IO_CYC, 32'hFFFFFFFE);
    rd(IO_CYC, v);
    check("cyc_load", v, 32'hFFFFFFFE);
    rd(IO_CYC, v);
    check("cyc_max", v, 32'hFFFFFFFF);
    rd(IO_CYC, v);
    check("cyc_wrap", v, 32'h00000000);

    // Simultaneous re & we is a read only
    wr(30'd7, 32'hCAFEF00D);
    bus(1'b1, 1'b1, 30'd7, 32'h11111111);
    check("rewe_rd", rmemdata, 32'hCAFEF00D);
    rd(30'd7, v);
    check("rewe_keep", v, 32'hCAFEF00D);

`ifdef MEMRSP_FAULT_EN
    rd(30'h20000009, v);
    check("unmapped_rd", v, 32'hDEADBEEF);
    check("fault_set", {31'b0, fault}, 32'd1);
    check("fault_addr", {2'b0, fault_addr}, 32'h20000009);
    rd(30'h00001005, v);
    check("alias_rd", v, 32'hDEADBEEF);
    check("fault_first", {2'b0, fault_addr}, 32'h20000009);
`else
    rd(30'h20000009, v);
    check("unmapped_rd", v, 32'h00000000);
    rd(30'h00001005, v);
    check("alias_rd", v, 32'h12345678);
`endif

    // Reset with a byte queued discards it
    wr(IO_CON, 32'h77);
    check("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_scratch", scratch, 32'd0);
    rd(IO_STA, v);
    check("mid_rst_status", v, 32'h00000002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
